serial_mag_compare_ctrl: RTL and testbench
==========================================

Name: serial_mag_compare_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands using one external 2-bit magnitude compare slice, reused once per digit pair.
- Compares 2 bits per cycle, MSB pair first.
- Accepts a start/operand pair, steps the slice through each digit pair and returns a registered gt/eq/lt result with a one-cycle done pulse.
- Sits between the operand source and the shared 2-bit comparator slice.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- NDIG (localparam), WIDTH/2, number of 2-bit digit pairs.
- IW (localparam), max(1, clog2(NDIG)), digit index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A, captured on the accepting edge.
- b_in  input  WIDTH  operand B, captured on the accepting edge.
- slice_a  output  2  current A digit pair to the slice.
- slice_b  output  2  current B digit pair to the slice.
- slice_gt  input  1  slice result: slice_a > slice_b (combinational, same cycle).
- slice_eq  input  1  slice result: slice_a == slice_b.
- slice_lt  input  1  slice result: slice_a < slice_b.
- busy  output  1  high while in CMP.
- done  output  1  one-cycle pulse, result valid.
- gt  output  1  registered result A > B.
- eq  output  1  registered result A == B.
- lt  output  1  registered result A < B.
- err  output  1  slice protocol error seen during this operation.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-high. While rst=1: state=IDLE, idx=0, captured operands=0, busy=0, done=0, gt=eq=lt=0, err=0. Asserting rst mid-operation aborts it with no done pulse.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - slice_a and slice_b drive 2'b00.
  - start=1 captures a_in/b_in and sets idx=NDIG-1.
  - Clears gt/eq/lt/err, then moves to CMP.
- CMP:
  - busy=1.
  - slice_a = A_reg[2*idx+1:2*idx]; slice_b likewise from B_reg; both combinational from registers.
  - Slice outputs are sampled on the same edge.
  - slice_eq=1 and idx>0: decrement idx, stay in CMP.
  - slice_eq=1 and idx==0: go to DONE. If no earlier pair differed, eq=1.
  - slice_eq=0: the first differing pair decides the result; gt<=slice_gt, lt<=slice_lt. Exit rule is set by the optional feature.
- Protocol check (CMP only): err<=1 (sticky until next accept) if the slice does not assert exactly one of gt/eq/lt in a cycle. The decision still follows slice_eq.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - slice_a and slice_b drive 2'b00.
- Results: gt/eq/lt/err hold from DONE until the next accepted start. Exactly one of gt/eq/lt is 1 after a clean operation.
- Latency: done asserts k edges after the edge that accepts start, where k = number of CMP cycles.
- Start handling: start in CMP or DONE is ignored, not queued. start held high continuously re-triggers one cycle after DONE, from IDLE.
- Operands: a_in and b_in may change freely after acceptance.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: the first differing pair latches gt/lt and goes to DONE immediately. k = (number of equal leading pairs) + 1.
- Undefined: k = NDIG always (constant latency).
  - The first differing pair sets a sticky decided flag and latches gt/lt.
  - Later pairs are still presented to the slice but do not change the result.
  - eq=1 only if decided=0 at idx==0.

Test Plan:
- WIDTH=8, A=0xA5, B=0xA5 -> slice sees pairs 2,2/2,2/1,1/1,1. done 4 edges after accept; eq=1, gt=lt=0.
- A=0x80, B=0x7F -> gt=1. done after 1 edge with SERIAL_CMP_EARLY_EXIT_EN, after 4 edges without. Without the macro, later pairs must not flip the result.
- A=0x34, B=0x37 -> lt=1, done after 4 edges in both builds.
- start held high through CMP with a_in changed mid-op -> result from the captured operands. Exactly one done pulse per operation; back-to-back operations separated by one IDLE cycle.
- rst pulsed during the 2nd CMP cycle -> all outputs 0 at once, no done. A following start with A=0x00, B=0xFF gives lt=1.
- Slice model forces gt=eq=lt=0 for one cycle -> err=1 at done. err is cleared on the next accepted start.

Source files
------------

// File: rtl/serial_mag_compare_ctrl.sv
// serial_mag_compare_ctrl: walks a shared 2-bit magnitude slice over two WIDTH-bit operands, MSB pair first.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing pair; otherwise latency is always WIDTH/2.
module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    input  logic             slice_gt,
    input  logic             slice_eq,
    input  logic             slice_lt,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             err
);
    localparam int NDIG = WIDTH / 2;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] a_reg, a_reg_n, b_reg, b_reg_n;
    logic             gt_n, eq_n, lt_n, err_n;
    logic             bad_slice, last;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
    logic             decided, decided_n;
`endif

    assign busy      = (state == CMP);
    assign done      = (state == DONE);
    assign slice_a   = busy ? a_reg[{idx, 1'b0} +: 2] : 2'b00;
    assign slice_b   = busy ? b_reg[{idx, 1'b0} +: 2] : 2'b00;
    assign bad_slice = !$onehot({slice_gt, slice_eq, slice_lt});
    assign last      = (idx == '0);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        a_reg_n = a_reg;
        b_reg_n = b_reg;
        gt_n    = gt;
        eq_n    = eq;
        lt_n    = lt;
        err_n   = err;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
        decided_n = decided;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CMP;
                    idx_n   = IW'(NDIG - 1);
                    a_reg_n = a_in;
                    b_reg_n = b_in;
                    gt_n    = 1'b0;
                    eq_n    = 1'b0;
                    lt_n    = 1'b0;
                    err_n   = 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
                    decided_n = 1'b0;
`endif
                end
            end
            CMP: begin
                err_n = err | bad_slice;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (!slice_eq) begin
                    gt_n    = slice_gt;
                    lt_n    = slice_lt;
                    state_n = DONE;
                end else if (last) begin
                    eq_n    = 1'b1;
                    state_n = DONE;
                end else begin
                    idx_n = idx - 1'b1;
                end
`else
                // Only the first differing pair may write the result; later pairs are walked for constant latency.
                if (!slice_eq && !decided) begin
                    decided_n = 1'b1;
                    gt_n      = slice_gt;
                    lt_n      = slice_lt;
                end
                if (last) begin
                    eq_n    = !decided && slice_eq;
                    state_n = DONE;
                end else begin
                    idx_n = idx - 1'b1;
                end
`endif
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            err   <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            decided <= 1'b0;
`endif
        end else begin
            state <= state_n;
            idx   <= idx_n;
            a_reg <= a_reg_n;
            b_reg <= b_reg_n;
            gt    <= gt_n;
            eq    <= eq_n;
            lt    <= lt_n;
            err   <= err_n;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            decided <= decided_n;
`endif
        end
    end
endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// tb_serial_mag_compare_ctrl: random and directed operations checked every cycle against a result/latency model.
module tb_serial_mag_compare_ctrl;
    localparam int W = 8;
    localparam int NDIG = W / 2;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, inj = 1'b0, fault_op = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic [1:0] slice_a, slice_b;
    logic slice_gt, slice_eq, slice_lt, busy, done, gt, eq, lt, err;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    // External slice; inj forces an illegal all-zero answer.
    assign slice_gt = !inj && (slice_a > slice_b);
    assign slice_eq = !inj && (slice_a == slice_b);
    assign slice_lt = !inj && (slice_a < slice_b);

    serial_mag_compare_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .slice_a(slice_a), .slice_b(slice_b),
        .slice_gt(slice_gt), .slice_eq(slice_eq), .slice_lt(slice_lt),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .err(err)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
        end
    endtask

    // Result and cycle count of one operation, straight from the comparison rules.
    function automatic void ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit f,
                                    output logic g, output logic e, output logic l,
                                    output logic r, output int k);
        int lead = 0;
        bit same = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            same = same && (((a >> (2 * i)) & 3) == ((b >> (2 * i)) & 3));
            if (same) lead++;
        end
        if (f) begin
            g = 1'b0; e = 1'b0; l = 1'b0; r = 1'b1;
            k = EARLY ? 1 : NDIG;
        end else begin
            g = a > b; e = a == b; l = a < b; r = 1'b0;
            k = (EARLY && lead < NDIG) ? lead + 1 : NDIG;
        end
    endfunction

    // Model: ph=0 idle, 1..mk compare cycles, mk+1 the done cycle.
    int ph = 0, mk = NDIG;
    logic [W-1:0] ma = '0, mb = '0;
    logic mgt = 0, meq = 0, mlt = 0, merr = 0, pgt, peq, plt, perr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; mgt = 0; meq = 0; mlt = 0; merr = 0;
        end else if (ph == 0) begin
            if (start) begin
                ma = a_in; mb = b_in;
                ref_cmp(a_in, b_in, fault_op, pgt, peq, plt, perr, mk);
                mgt = 0; meq = 0; mlt = 0; merr = 0;
                ph = 1;
            end
        end else if (ph <= mk) begin
            ph++;
            if (ph == mk + 1) begin
                mgt = pgt; meq = peq; mlt = plt; merr = perr;
            end
        end else begin
            ph = 0;
        end
    end

    always @(posedge clk) begin
        logic [W-1:0] ta, tb;
        logic [1:0] ea, eb;
        #2;
        ta = ma >> (2 * (NDIG - ph));
        tb = mb >> (2 * (NDIG - ph));
        ea = (ph >= 1 && ph <= mk) ? ta[1:0] : 2'b00;
        eb = (ph >= 1 && ph <= mk) ? tb[1:0] : 2'b00;
        chk("busy", busy, (ph >= 1 && ph <= mk));
        chk("done", done, (ph == mk + 1));
        chk("slice_a", slice_a, ea);
        chk("slice_b", slice_b, eb);
        if (ph == 0 || ph == mk + 1) begin
            chk("gt", gt, mgt);
            chk("eq", eq, meq);
            chk("lt", lt, mlt);
            chk("err", err, merr);
        end
    end

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (ph != 0 && g < 30) begin
            @(negedge clk);
            g++;
        end
        if (ph != 0) begin
            total++; bad++;
            $display("FAIL idle_wait actual=busy required=idle");
        end
    endtask

    // One operation; lat = edges from the accepting edge to done (21 on timeout).
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit f, output int lat);
        wait_idle();
        a_in = a; b_in = b; fault_op = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0; fault_op = 1'b0; inj = f;
        a_in = W'($urandom); b_in = W'($urandom);
        lat = 21;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #2;
            inj = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic g, e, l, r;
        int k;
        ref_cmp(8'hA5, 8'hA5, 1'b0, g, e, l, r, k);
        chk("model_a5_eq", {g, e, l, r}, 4'b0100);
        chk("model_a5_k", k, 4);
        ref_cmp(8'h80, 8'h7F, 1'b0, g, e, l, r, k);
        chk("model_80_gt", {g, e, l}, 3'b100);
        chk("model_80_k", k, EARLY ? 1 : 4);
        ref_cmp(8'h34, 8'h37, 1'b0, g, e, l, r, k);
        chk("model_34_lt", {g, e, l}, 3'b001);
        chk("model_34_k", k, 4);

        #1;
        chk("rst_outs", {busy, done, gt, eq, lt, err, slice_a, slice_b}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op(8'hA5, 8'hA5, 1'b0, lat);
        chk("a5_lat", lat, 4);
        chk("a5_res", {gt, eq, lt, err}, 4'b0100);
        op(8'h80, 8'h7F, 1'b0, lat);
        chk("80_lat", lat, EARLY ? 1 : 4);
        chk("80_res", {gt, eq, lt}, 3'b100);
        op(8'h34, 8'h37, 1'b0, lat);
        chk("34_lat", lat, 4);
        chk("34_res", {gt, eq, lt}, 3'b001);
        op(8'hA5, 8'hA5, 1'b1, lat);
        chk("fault_err", err, 1);
        chk("fault_lat", lat, EARLY ? 1 : 4);
        op(8'h12, 8'h21, 1'b0, lat);
        chk("err_clear", {err, lt}, 2'b01);

        // start held high with operands churning
        wait_idle();
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a_in = W'($urandom); b_in = (i % 3 == 0) ? a_in : W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;

        // reset during the second compare cycle
        wait_idle();
        a_in = 8'h55; b_in = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_abort", {busy, done, gt, eq, lt, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        op(8'h00, 8'hFF, 1'b0, lat);
        chk("post_rst_lt", {gt, eq, lt}, 3'b001);
        chk("post_rst_lat", lat, EARLY ? 1 : 4);

        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 1) == 1) ? (a ^ W'($urandom_range(0, 15))) : W'($urandom);
            op(a, b, $urandom_range(0, 9) == 0, lat);
            chk("rand_lat", lat, mk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
